pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline registers: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Detects load-use hazards, applies memory back-pressure and redirects on taken branches.
- After each redirect, runs a wrong-path shadow window that kills in-flight fetches.
- Every pipeline register takes one stall bit (hold) and one flush bit (load a bubble) from this block.

Parameters:
SHADOW, 1, cycles after a redirect during which IF/ID is also flushed (1..7).
TIMEOUT, 256, consecutive mem_req cycles that raise busy_err (2..65535).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
id_re1  in  1  ID reads rs1
id_ra1  in  5  ID rs1 address
id_re2  in  1  ID reads rs2
id_ra2  in  5  ID rs2 address
ex_ld  in  1  instruction in EX is a load
ex_we  in  1  EX writes rd
ex_wa  in  5  EX rd address
ex_br  in  1  EX branch/jump taken (level, valid while the instruction sits at ID/EX output)
ex_br_addr  in  32  redirect target
if_req  in  1  IF not ready (fetch pending)
mem_req  in  1  MEM stage busy (load/store pending)
stall  out  5  hold: [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb
flush  out  5  bubble into register i (same bit order)
pc_redir  out  1  load pc from pc_target
pc_target  out  32  redirect address (= ex_br_addr)
busy_err  out  1  sticky memory-timeout flag
perf_stall  out  32  stall-cycle counter (see optional feature)
perf_flush  out  32  redirect counter (see optional feature)

Behaviour:
- Registered state: fsm {RUN, MEM_WAIT}, shadow_cnt[2:0], wd_cnt[15:0], busy_err.
- stall, flush and pc_redir are combinational from the inputs and the registered state. Decisions take effect at the next clk edge (0-cycle decision latency).
- While rst=1: stall=0, flush=5'b11111, pc_redir=0. All registers clear on the edge: fsm=RUN, counters=0, busy_err=0.
- Load-use hazard: ex_ld & ex_we & ex_wa!=0 & ((id_re1 & id_ra1==ex_wa) | (id_re2 & id_ra2==ex_wa)).
- Per-cycle decisions, highest priority first:
  1. mem_req=1: stall=5'b01111, flush=5'b10000, pc_redir=0. ex_br is ignored because the branch is held in ID/EX and is re-seen after release. fsm->MEM_WAIT.
  2. ex_br=1: stall=0, flush=5'b00110, pc_redir=1. shadow_cnt<=SHADOW. This overrides load-use and if_req.
  3. Load-use: stall=5'b00011, flush=5'b00100. Exactly one bubble, because the load leaves EX on the next edge.
  4. if_req=1: stall=5'b00001, flush=5'b00010.
  5. Otherwise stall=0, flush=0.
- Shadow window:
  - When shadow_cnt!=0 and mem_req=0, flush[1] is forced to 1 (OR into the decision above) and shadow_cnt decrements.
  - When mem_req=1, shadow_cnt holds.
  - A new ex_br inside the window reloads shadow_cnt to SHADOW.
- FSM:
  - RUN->MEM_WAIT when mem_req=1.
  - MEM_WAIT->RUN on the first cycle with mem_req=0. In that cycle, priorities 2-5 are evaluated normally.
- Watchdog:
  - wd_cnt increments on every mem_req=1 cycle and clears to 0 when mem_req=0.
  - On the edge where wd_cnt==TIMEOUT-1 and mem_req=1, busy_err<=1.
  - busy_err stays set until rst. wd_cnt saturates at TIMEOUT-1.
- Simultaneous mem_req and ex_br: no redirect that cycle. The redirect occurs in the first cycle after mem_req falls, provided ex_br is still high.
- Reset mid-MEM_WAIT or mid-shadow aborts immediately; no pending redirect survives.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined:
  - perf_stall increments on every cycle with stall!=0.
  - perf_flush increments on every cycle with pc_redir=1.
  - Both counters wrap modulo 2^32 and clear on rst.
- Undefined: both ports are driven constant 0 and no counter flops are built.

Decomposition:
- Shared package pipe_pkg holds:
  - Stage index constants PC_I=0, IFID_I=1, IDEX_I=2, EXMEM_I=3, MEMWB_I=4.
  - The fsm state enum {RUN, MEM_WAIT}.
  - Stall/flush pattern constants (MEM_STALL=5'b01111, etc.).
- One natural sub-module: pipe_hazard_det, the pure combinational load-use comparator (inputs id_re*/id_ra*/ex_ld/ex_we/ex_wa, output hazard). Instantiated once.

Test Plan:
1. rst=1 for 2 cycles, then release -> stall=0, flush=5'b11111 during reset. After release stall=0, flush=0, busy_err=0.
2. ex_ld=1, ex_we=1, ex_wa=5, id_re2=1, id_ra2=5 for 1 cycle -> stall=5'b00011, flush=5'b00100. With ex_wa=0 instead -> no stall.
3. ex_br=1 with ex_br_addr=0x100, SHADOW=2 -> pc_redir=1, pc_target=0x100, flush=5'b00110. The next 2 cycles show flush[1]=1, then flush returns to 0.
4. mem_req=1 for 3 cycles with ex_br=1 throughout, then mem_req=0 -> 3 cycles of stall=5'b01111, flush=5'b10000, pc_redir=0. The 4th cycle shows pc_redir=1 exactly once.
5. TIMEOUT=4, mem_req=1 for 4 cycles -> busy_err rises after the 4th edge and stays 1 after mem_req drops; cleared only by rst.
6. ex_br, load-use and if_req asserted together -> branch wins: flush=5'b00110, stall=0. With PIPE_CTRL_PERF_EN defined, perf_flush=1 and perf_stall=0 after that cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: stage indices,
// controller state encoding and the fixed stall/flush patterns.
package pipe_pkg;

  // Bit positions in the stall/flush vectors, front of the pipe first.
  localparam int PC_I    = 0;
  localparam int IFID_I  = 1;
  localparam int IDEX_I  = 2;
  localparam int EXMEM_I = 3;
  localparam int MEMWB_I = 4;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } pipe_state_e;

  // Memory back-pressure: hold everything upstream of MEM/WB and retire
  // a bubble into MEM/WB so the stalled access is not written back twice.
  localparam logic [4:0] MEM_STALL = 5'b01111;
  localparam logic [4:0] MEM_FLUSH = 5'b10000;
  // Taken branch: squash the two younger instructions (IF/ID, ID/EX).
  localparam logic [4:0] BR_STALL  = 5'b00000;
  localparam logic [4:0] BR_FLUSH  = 5'b00110;
  // Load-use: hold PC and IF/ID, inject one bubble into ID/EX.
  localparam logic [4:0] LU_STALL  = 5'b00011;
  localparam logic [4:0] LU_FLUSH  = 5'b00100;
  // Fetch not ready: hold PC, bubble into IF/ID.
  localparam logic [4:0] IF_STALL  = 5'b00001;
  localparam logic [4:0] IF_FLUSH  = 5'b00010;
  // Reset: every register loads a bubble, nothing held.
  localparam logic [4:0] RST_FLUSH = 5'b11111;
  localparam logic [4:0] NO_CTRL   = 5'b00000;

endpackage

// File: rtl/pipe_hazard_det.sv
// Load-use hazard comparator: flags an ID-stage source register that is
// written by a load currently in EX. Purely combinational.
module pipe_hazard_det (
  input  logic       id_re1_i,
  input  logic [4:0] id_ra1_i,
  input  logic       id_re2_i,
  input  logic [4:0] id_ra2_i,
  input  logic       ex_ld_i,
  input  logic       ex_we_i,
  input  logic [4:0] ex_wa_i,
  output logic       hazard_o
);

  logic src1_hit;
  logic src2_hit;

  // Register x0 never carries a dependency, so a zero destination is ignored.
  always_comb begin
    src1_hit = id_re1_i && (id_ra1_i == ex_wa_i);
    src2_hit = id_re2_i && (id_ra2_i == ex_wa_i);
    hazard_o = ex_ld_i && ex_we_i && (ex_wa_i != 5'd0) && (src1_hit || src2_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined;
// otherwise perf_stall/perf_flush are tied to zero.
//
// Control semantics: stall[i]=1 means register i holds its value on the next
// edge; flush[i]=1 means register i loads a bubble on the next edge. if_req and
// mem_req are "not ready" levels from IF and MEM; the stage is ready on a
// cycle where its request is low. Decisions are combinational and apply at the
// coming clock edge.
module pipe_ctrl import pipe_pkg::*; #(
  parameter int SHADOW  = 1,
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_re1,
  input  logic [4:0]  id_ra1,
  input  logic        id_re2,
  input  logic [4:0]  id_ra2,
  input  logic        ex_ld,
  input  logic        ex_we,
  input  logic [4:0]  ex_wa,
  input  logic        ex_br,
  input  logic [31:0] ex_br_addr,
  input  logic        if_req,
  input  logic        mem_req,
  output logic [4:0]  stall,
  output logic [4:0]  flush,
  output logic        pc_redir,
  output logic [31:0] pc_target,
  output logic        busy_err,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush,
  output logic        dbg_state
);

  localparam logic [2:0]  SHADOW_LD = 3'(SHADOW);
  localparam logic [15:0] WD_LAST   = 16'(TIMEOUT - 1);

  logic        hazard;
  pipe_state_e state_q, state_d;
  logic [2:0]  shadow_q, shadow_d;
  logic [15:0] wd_q, wd_d;
  logic        busy_q, busy_d;

  pipe_hazard_det u_hazard (
    .id_re1_i (id_re1),
    .id_ra1_i (id_ra1),
    .id_re2_i (id_re2),
    .id_ra2_i (id_ra2),
    .ex_ld_i  (ex_ld),
    .ex_we_i  (ex_we),
    .ex_wa_i  (ex_wa),
    .hazard_o (hazard)
  );

  // Priority decision; the wrong-path shadow ORs an IF/ID flush on top.
  always_comb begin
    stall    = NO_CTRL;
    flush    = NO_CTRL;
    pc_redir = 1'b0;
    if (rst) begin
      flush = RST_FLUSH;
    end else if (mem_req) begin
      // A branch seen here stays in ID/EX and is acted on after release.
      stall = MEM_STALL;
      flush = MEM_FLUSH;
    end else if (ex_br) begin
      stall    = BR_STALL;
      flush    = BR_FLUSH;
      pc_redir = 1'b1;
    end else if (hazard) begin
      stall = LU_STALL;
      flush = LU_FLUSH;
    end else if (if_req) begin
      stall = IF_STALL;
      flush = IF_FLUSH;
    end
    if (!rst && !mem_req && (shadow_q != 3'd0)) begin
      flush[IFID_I] = 1'b1;
    end
  end

  // Next-state for the controller FSM, shadow window and memory watchdog.
  always_comb begin
    state_d  = mem_req ? MEM_WAIT : RUN;
    shadow_d = shadow_q;
    wd_d     = wd_q;
    busy_d   = busy_q;
    if (!mem_req) begin
      if (ex_br) begin
        shadow_d = SHADOW_LD;
      end else if (shadow_q != 3'd0) begin
        shadow_d = shadow_q - 3'd1;
      end
    end
    if (mem_req) begin
      if (wd_q == WD_LAST) begin
        busy_d = 1'b1;
      end else begin
        wd_d = wd_q + 16'd1;
      end
    end else begin
      wd_d = 16'd0;
    end
  end

  // Registered state, cleared synchronously by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      shadow_q <= 3'd0;
      wd_q     <= 16'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      wd_q     <= wd_d;
      busy_q   <= busy_d;
    end
  end

  assign pc_target = ex_br_addr;
  assign busy_err  = busy_q;
  assign dbg_state = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  // Free-running event counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      if (stall != NO_CTRL) perf_stall_q <= perf_stall_q + 32'd1;
      if (pc_redir)         perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`else
  assign perf_stall = 32'd0;
  assign perf_flush = 32'd0;
`endif

endmodule
